// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and full/empty flags.
// Storage is DEPTH x WIDTH. The read and write pointers carry one extra wrap bit,
// so full and empty can be told apart when the addresses are equal.
//
// Handshake: a write is accepted when wr_en is high and full is low at the
// rising edge. A read is accepted when rd_en is high and empty is low at the
// rising edge. A request made when its flag blocks it is ignored with no side
// effects. The flags are decoded from registered pointers only, so no input
// reaches an output combinationally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_acc;
  logic             rd_acc;

  // Flag decode and acceptance, all from pre-edge pointer values
  always_comb begin
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    wr_acc = wr_en && !full;
    rd_acc = rd_en && !empty;
  end

  // Pointer advance; reset discards all stored words logically
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are never reset, only the pointers are
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  // Registered read data; holds whenever no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and random stimulus against a queue-based reference.
module tb_sync_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  // Reference model: the stored words in order, plus the last word read out
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model_dout;

  int n_checks;
  int n_errors;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data_out"}, data_out, model_dout);
    check({tag, ".full"}, {31'b0, full}, {31'b0, exp_q.size() == DEPTH});
    check({tag, ".empty"}, {31'b0, empty}, {31'b0, exp_q.size() == 0});
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d, input string tag);
    bit pre_full;
    bit pre_empty;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    pre_full  = (exp_q.size() == DEPTH);
    pre_empty = (exp_q.size() == 0);
    if (r && !pre_empty) model_dout = exp_q.pop_front();
    if (w && !pre_full) exp_q.push_back(d);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset in mid-cycle, held across edges with input activity,
  // released between edges
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_dout = '0;
    check_all("reset_async");
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      rd_en   = 1'($urandom_range(0, 1));
      data_in = $urandom;
      @(posedge clk);
      #1;
      check_all("reset_hold");
    end
    #3;
    rst_n   = 1'b1;
    wr_en   = 1'b1;
    data_in = 32'h55;
    #1;
    check_all("reset_release");
  endtask

  initial begin
    int pick;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    data_in    = '0;
    model_dout = '0;
    #12;

    // Reset with activity, then first post-release edge writes 0x55
    do_reset();
    step(1'b1, 1'b0, 32'h55, "first_write");
    step(1'b0, 1'b1, 32'h0, "first_read");
    check("first_read_val", data_out, 32'h55);

    // Fill to full with 1..16, then a dropped 17th write
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, WIDTH'(i), "fill");
    check("fill_full", {31'b0, full}, 32'd1);
    step(1'b1, 1'b0, 32'd99, "fill_drop");

    // Drain: 1..16 in order, then an extra read keeps 16
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 32'h0, "drain");
      check("drain_val", data_out, WIDTH'(i));
    end
    step(1'b0, 1'b1, 32'h0, "drain_extra");
    check("drain_hold", data_out, 32'd16);

    // Streaming with one resident word
    step(1'b1, 1'b0, 32'd1, "stream_prime");
    for (int i = 2; i <= 18; i++) begin
      step(1'b1, 1'b1, WIDTH'(i), "stream");
      check("stream_val", data_out, WIDTH'(i - 1));
    end
    step(1'b0, 1'b1, 32'h0, "stream_drain");

    // Wrap-around with 8 resident words
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, $urandom, "wrap_fill");
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, $urandom, "wrap_stream");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h0, "wrap_drain");

    // Full with both high: read accepted, write dropped
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'h100 + WIDTH'(i), "bnd_fill");
    step(1'b1, 1'b1, 32'hdead, "bnd_full_both");
    check("bnd_full_out", data_out, 32'h100);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'h0, "bnd_drain");

    // Empty with both high: write accepted, data_out holds
    step(1'b1, 1'b1, 32'hbeef, "bnd_empty_both");
    step(1'b0, 1'b1, 32'h0, "bnd_empty_read");
    check("bnd_empty_val", data_out, 32'hbeef);

    // Random traffic, biased sometimes to fill, sometimes to drain
    for (int i = 0; i < 400; i++) begin
      pick = (i / 50) % 2;
      step(1'($urandom_range(0, 3) > pick), 1'($urandom_range(0, 3) > 1 - pick),
           $urandom, "random");
    end

    // Reset mid-stream, then first read returns first post-reset write
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, $urandom, "pre_reset");
    do_reset();
    step(1'b1, 1'b0, 32'h77, "post_reset_w1");
    step(1'b1, 1'b1, 32'h78, "post_reset_w2");
    check("post_reset_first", data_out, 32'h77);
    step(1'b0, 1'b1, 32'h0, "post_reset_r2");
    check("post_reset_second", data_out, 32'h78);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
